// File: rtl/gpio_pad_pkg.sv
// rtl/gpio_pad_pkg.sv - edge-mode encodings, pad reset values and edge qualification helper
// Shared by gpio_pad_chan and gpio_pad_bank.
package gpio_pad_pkg;

  typedef logic [1:0] edge_mode_t;

  localparam edge_mode_t EDGE_NONE = 2'b00;
  localparam edge_mode_t EDGE_RISE = 2'b01;
  localparam edge_mode_t EDGE_FALL = 2'b10;
  localparam edge_mode_t EDGE_BOTH = 2'b11;

  // Receivers come up enabled so the bank can observe pads straight out of reset.
  localparam logic PAD_REN_RST = 1'b1;
  localparam logic PAD_CTL_RST = 1'b0;

  function automatic logic edge_hit(input edge_mode_t mode, input logic rise, input logic fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gpio_pad_chan.sv
// rtl/gpio_pad_chan.sv - one pad channel: control registers, synchroniser, debounce, edge detect, pending flag
module gpio_pad_chan
  import gpio_pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 8,
  parameter int DB_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_oe,
  input  logic       i_out,
  input  logic       i_ie,
  input  logic       i_pu,
  input  logic       i_pd,
  input  edge_mode_t i_edge,
  input  logic       i_clr,
  input  logic       i_src,
  output logic       o_din,
  output logic       o_en,
  output logic       o_ren,
  output logic       o_pu,
  output logic       o_pd,
  output logic       o_in_val,
  output logic       o_pend
);

  logic                   r_din;
  logic                   r_en;
  logic                   r_ren;
  logic                   r_pu;
  logic                   r_pd;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_in_val;
  logic                   r_prev;
  logic                   r_pend;
  logic                   w_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_hit;

  // Conflicting pull requests resolve to neither pull rather than fighting on the pad.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_din <= PAD_CTL_RST;
      r_en  <= PAD_CTL_RST;
      r_ren <= PAD_REN_RST;
      r_pu  <= PAD_CTL_RST;
      r_pd  <= PAD_CTL_RST;
    end else begin
      r_din <= i_out;
      r_en  <= i_oe;
      r_ren <= i_ie;
      r_pu  <= i_pu & ~i_pd;
      r_pd  <= i_pd & ~i_pu;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  generate
    if (DB_CYCLES == 0) begin : g_no_db
      always_ff @(posedge clk) begin
        if (rst) begin
          r_in_val <= 1'b0;
        end else begin
          r_in_val <= w_s;
        end
      end
    end else begin : g_db
      localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
      logic [DB_W-1:0] r_cnt;

      // The count only advances while the synced value disagrees with the filtered one.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt    <= '0;
          r_in_val <= 1'b0;
        end else if (w_s == r_in_val) begin
          r_cnt <= '0;
        end else if (r_cnt == DB_LAST) begin
          r_in_val <= w_s;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + DB_W'(1);
        end
      end
    end
  endgenerate

  assign w_rise = r_in_val & ~r_prev;
  assign w_fall = ~r_in_val & r_prev;
  assign w_hit  = edge_hit(i_edge, w_rise, w_fall);

  // A new event beats a clear strobe arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_prev <= r_in_val;
      r_pend <= w_hit | (r_pend & ~i_clr);
    end
  end

  assign o_din    = r_din;
  assign o_en     = r_en;
  assign o_ren    = r_ren;
  assign o_pu     = r_pu;
  assign o_pd     = r_pd;
  assign o_in_val = r_in_val;
  assign o_pend   = r_pend;

endmodule

// File: rtl/gpio_pad_bank.sv
// rtl/gpio_pad_bank.sv - NUM_CH-channel GPIO pad bank with debounced inputs and edge interrupts
// Optional GPIO_PAD_BANK_LOOPBACK_EN adds lb_en to feed the driven value back into the synchronisers.
module gpio_pad_bank
  import gpio_pad_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 8,
  parameter int DB_CYCLES   = 16
) (
  input  logic                clk,
  input  logic                rst,
`ifdef GPIO_PAD_BANK_LOOPBACK_EN
  input  logic                lb_en,
`endif
  input  logic [NUM_CH-1:0]   cfg_oe,
  input  logic [NUM_CH-1:0]   cfg_out,
  input  logic [NUM_CH-1:0]   cfg_ie,
  input  logic [NUM_CH-1:0]   cfg_pu,
  input  logic [NUM_CH-1:0]   cfg_pd,
  input  logic [2*NUM_CH-1:0] cfg_edge,
  input  logic [NUM_CH-1:0]   irq_mask,
  input  logic [NUM_CH-1:0]   irq_clr,
  output logic [NUM_CH-1:0]   pad_din,
  output logic [NUM_CH-1:0]   pad_en,
  output logic [NUM_CH-1:0]   pad_ren,
  output logic [NUM_CH-1:0]   pad_pu,
  output logic [NUM_CH-1:0]   pad_pd,
  input  logic [NUM_CH-1:0]   pad_dout,
  output logic [NUM_CH-1:0]   in_val,
  output logic [NUM_CH-1:0]   irq_pend,
  output logic                irq
);

  logic [NUM_CH-1:0] w_src;

`ifdef GPIO_PAD_BANK_LOOPBACK_EN
  assign w_src = lb_en ? (pad_din & pad_en) : pad_dout;
`else
  assign w_src = pad_dout;
`endif

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      gpio_pad_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_W        (DB_W),
        .DB_CYCLES   (DB_CYCLES)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .i_oe     (cfg_oe[g]),
        .i_out    (cfg_out[g]),
        .i_ie     (cfg_ie[g]),
        .i_pu     (cfg_pu[g]),
        .i_pd     (cfg_pd[g]),
        .i_edge   (cfg_edge[2*g +: 2]),
        .i_clr    (irq_clr[g]),
        .i_src    (w_src[g]),
        .o_din    (pad_din[g]),
        .o_en     (pad_en[g]),
        .o_ren    (pad_ren[g]),
        .o_pu     (pad_pu[g]),
        .o_pd     (pad_pd[g]),
        .o_in_val (in_val[g]),
        .o_pend   (irq_pend[g])
      );
    end
  endgenerate

  assign irq = |(irq_pend & irq_mask);

endmodule

// File: tb/tb_gpio_pad_bank.sv
// tb/tb_gpio_pad_bank.sv - scoreboard bench for gpio_pad_bank against a window-based reference model
module tb_gpio_pad_bank;

  localparam int NUM_CH = 8;
  localparam int SYNC   = 2;
  localparam int DB     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              lb_en;
  logic [NUM_CH-1:0] cfg_oe, cfg_out, cfg_ie, cfg_pu, cfg_pd, irq_mask, irq_clr, pad_dout;
  logic [2*NUM_CH-1:0] cfg_edge;
  logic [NUM_CH-1:0] pad_din, pad_en, pad_ren, pad_pu, pad_pd, in_val, irq_pend;
  logic              irq;

  gpio_pad_bank #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .DB_W(8), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef GPIO_PAD_BANK_LOOPBACK_EN
    .lb_en    (lb_en),
`endif
    .cfg_oe   (cfg_oe),
    .cfg_out  (cfg_out),
    .cfg_ie   (cfg_ie),
    .cfg_pu   (cfg_pu),
    .cfg_pd   (cfg_pd),
    .cfg_edge (cfg_edge),
    .irq_mask (irq_mask),
    .irq_clr  (irq_clr),
    .pad_din  (pad_din),
    .pad_en   (pad_en),
    .pad_ren  (pad_ren),
    .pad_pu   (pad_pu),
    .pad_pd   (pad_pd),
    .pad_dout (pad_dout),
    .in_val   (in_val),
    .irq_pend (irq_pend),
    .irq      (irq)
  );

  typedef struct {
    logic [NUM_CH-1:0] din, en, ren, pu, pd, in_val, pend;
    logic              irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: delay line of sampled pad values and a history window of synced values.
  logic [NUM_CH-1:0] m_din, m_en, m_ren, m_pu, m_pd, m_in_val, m_prev, m_pend;
  logic [NUM_CH-1:0] sync_q[$];
  logic [NUM_CH-1:0] win_q[$];

  task automatic model_reset();
    m_din = '0; m_en = '0; m_ren = '1; m_pu = '0; m_pd = '0;
    m_in_val = '0; m_prev = '0; m_pend = '0;
    sync_q = {};
    win_q  = {};
    for (int i = 0; i < SYNC; i++) sync_q.push_back('0);
    for (int i = 0; i < DB - 1; i++) win_q.push_back('0);
  endtask

  // Filtered value flips once the last DB synced samples all disagree with it.
  task automatic model_step();
    logic [NUM_CH-1:0] src, s_cur, flip, rise, fall, hit;
    logic [1:0] mode;
    exp_t e;
    if (rst) begin
      model_reset();
    end else begin
      src = pad_dout;
`ifdef GPIO_PAD_BANK_LOOPBACK_EN
      if (lb_en) src = m_din & m_en;
`endif
      s_cur = sync_q[0];
      for (int b = 0; b < NUM_CH; b++) begin
        flip[b] = (s_cur[b] != m_in_val[b]);
        foreach (win_q[k]) if (win_q[k][b] == m_in_val[b]) flip[b] = 1'b0;
      end
      if (DB == 0) flip = s_cur ^ m_in_val;
      rise = m_in_val & ~m_prev;
      fall = m_prev & ~m_in_val;
      for (int b = 0; b < NUM_CH; b++) begin
        mode = cfg_edge[2*b +: 2];
        hit[b] = (mode == 2'b01 && rise[b]) || (mode == 2'b10 && fall[b]) ||
                 (mode == 2'b11 && (rise[b] || fall[b]));
      end
      m_pend   = hit | (m_pend & ~irq_clr);
      m_prev   = m_in_val;
      m_in_val = m_in_val ^ flip;
      void'(sync_q.pop_front());
      sync_q.push_back(src);
      if (DB > 1) begin
        win_q.push_back(s_cur);
        void'(win_q.pop_front());
      end
      m_din = cfg_out;
      m_en  = cfg_oe;
      m_ren = cfg_ie;
      m_pu  = cfg_pu & ~cfg_pd;
      m_pd  = cfg_pd & ~cfg_pu;
    end
    e.din = m_din; e.en = m_en; e.ren = m_ren; e.pu = m_pu; e.pd = m_pd;
    e.in_val = m_in_val; e.pend = m_pend;
    e.irq = |(m_pend & irq_mask);
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pad_din",  pad_din,  e.din);
        chk("pad_en",   pad_en,   e.en);
        chk("pad_ren",  pad_ren,  e.ren);
        chk("pad_pu",   pad_pu,   e.pu);
        chk("pad_pd",   pad_pd,   e.pd);
        chk("in_val",   in_val,   e.in_val);
        chk("irq_pend", irq_pend, e.pend);
        chk("irq",      {{(NUM_CH-1){1'b0}}, irq}, {{(NUM_CH-1){1'b0}}, e.irq});
      end
    end
  end

  initial begin : watchdog
    #400000;
    errors++;
    $display("FAIL watchdog t=%0t actual=timeout expected=completion", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : driver
    model_reset();
    rst = 1'b1; lb_en = 1'b0;
    cfg_oe = 8'hFF; cfg_out = '0; cfg_ie = 8'hFF; cfg_pu = '0; cfg_pd = '0;
    cfg_edge = '0; irq_mask = '0; irq_clr = '0; pad_dout = '0;
    tick(3);
    rst = 1'b0;
    tick(4);

    // Debounce on channel 0: short glitch, then a long hold.
    pad_dout[0] = 1'b1; tick(10);
    pad_dout[0] = 1'b0; tick(25);
    pad_dout[0] = 1'b1; tick(20);
    pad_dout[0] = 1'b0; tick(25);

    // Edge modes on channels 1..3.
    cfg_edge = 16'h00E4;
    irq_clr = 8'hFF; tick(1); irq_clr = '0;
    pad_dout[3:1] = 3'b111; tick(25);
    pad_dout[3:1] = 3'b000; tick(25);

    // Clear strobe coinciding with a new qualified edge on channel 3.
    pad_dout[3] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      irq_clr[3] = m_in_val[3] ^ m_prev[3];
      tick(1);
    end
    irq_clr = '0; tick(3);
    irq_clr[3] = 1'b1; tick(1); irq_clr = '0; tick(3);

    // Mask and conflicting pulls.
    irq_mask = 8'h00; tick(3);
    irq_mask = 8'h04; tick(3);
    cfg_pu[5] = 1'b1; cfg_pd[5] = 1'b1; tick(3);
    cfg_pd[5] = 1'b0; tick(3);
    rst = 1'b1; tick(1); rst = 1'b0; tick(3);

`ifdef GPIO_PAD_BANK_LOOPBACK_EN
    lb_en = 1'b1; pad_dout = '0; cfg_oe[6] = 1'b1; cfg_edge = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      cfg_out[6] = ~cfg_out[6];
      tick(30);
    end
    lb_en = 1'b0;
`endif

    // Randomised phase.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        cfg_oe = 8'($urandom); cfg_out = 8'($urandom); cfg_ie = 8'($urandom);
        cfg_pu = 8'($urandom); cfg_pd = 8'($urandom); cfg_edge = 16'($urandom);
      end
      if ($urandom_range(0, 19) == 0) irq_mask = 8'($urandom);
      irq_clr = 8'($urandom) & 8'($urandom) & 8'($urandom);
      for (int b = 0; b < NUM_CH; b++)
        if ($urandom_range(0, 19) == 0) pad_dout[b] = ~pad_dout[b];
      rst = ($urandom_range(0, 499) == 0);
`ifdef GPIO_PAD_BANK_LOOPBACK_EN
      if ($urandom_range(0, 99) == 0) lb_en = ~lb_en;
`endif
      tick(1);
    end
    rst = 1'b0; irq_clr = '0;
    tick(2);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
